// File: rtl/de4_sopc_edge_event_pkg.sv
// de4_sopc_edge_event_pkg: edge_sel encoding, parameter range limits and event decode
package de4_sopc_edge_event_pkg;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      RISE = 2'b01,
      FALL = 2'b10,
      BOTH = 2'b11
   } edge_mode_t;

   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 32;
   localparam int SYNC_MIN  = 0;
   localparam int SYNC_MAX  = 3;
   localparam int PULSE_MIN = 1;
   localparam int PULSE_MAX = 255;

   function automatic logic edge_event(edge_mode_t mode, logic sampled, logic prev);
      return (mode == BOTH) ? (sampled ^ prev) :
             (mode == RISE) ? (sampled & ~prev) :
             (mode == FALL) ? (~sampled & prev) : 1'b0;
   endfunction

endpackage

// File: rtl/de4_sopc_edge_event_channel.sv
// de4_sopc_edge_event_channel: one channel of sync, edge decode, retriggerable pulse and sticky flag
// Sticky flag compiled in only with DE4_SOPC_EDGE_EVENT_STICKY_EN.
module de4_sopc_edge_event_channel
   import de4_sopc_edge_event_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_LEN   = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       data_in,
   input  logic [1:0] edge_sel,
   input  logic       status_clr,
   output logic       data_out,
   output logic       status
);

   localparam int CW = $clog2(PULSE_LEN + 1);

   logic          w_sampled;
   logic          w_event;
   logic          r_prev;
   logic [CW-1:0] r_cnt;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_sampled = data_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_sync;
         always_ff @(posedge clock or negedge reset_n)
            if (!reset_n) r_sync <= '0;
            else          r_sync <= (r_sync << 1) | SYNC_STAGES'(data_in);
         assign w_sampled = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   assign w_event = edge_event(edge_mode_t'(edge_sel), w_sampled, r_prev);

   // an event always reloads the full length, so retriggers extend the pulse
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         r_prev <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_prev <= w_sampled;
         r_cnt  <= w_event ? CW'(PULSE_LEN) : (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
      end

   assign data_out = |r_cnt;

`ifdef DE4_SOPC_EDGE_EVENT_STICKY_EN
   logic r_status;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) r_status <= 1'b0;
      else          r_status <= w_event | (r_status & ~status_clr);
   assign status = r_status;
`else
   logic w_unused_clr;
   assign w_unused_clr = status_clr;
   assign status       = 1'b0;
`endif

endmodule

// File: rtl/de4_sopc_edge_event_unit.sv
// de4_sopc_edge_event_unit: WIDTH independent edge-to-pulse channels with sticky status and irq
// Status/irq logic compiled in only with DE4_SOPC_EDGE_EVENT_STICKY_EN.
module de4_sopc_edge_event_unit
   import de4_sopc_edge_event_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_LEN   = 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [2*WIDTH-1:0] edge_sel,
   output logic [WIDTH-1:0]   data_out,
   output logic [WIDTH-1:0]   status,
   input  logic [WIDTH-1:0]   status_clr,
   input  logic [WIDTH-1:0]   irq_en,
   output logic               irq
);

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_ch
         de4_sopc_edge_event_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .PULSE_LEN  (PULSE_LEN)
         ) u_ch (
            .clock     (clock),
            .reset_n   (reset_n),
            .data_in   (data_in[i]),
            .edge_sel  (edge_sel[2*i +: 2]),
            .status_clr(status_clr[i]),
            .data_out  (data_out[i]),
            .status    (status[i])
         );
      end
   endgenerate

`ifdef DE4_SOPC_EDGE_EVENT_STICKY_EN
   logic r_irq;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) r_irq <= 1'b0;
      else          r_irq <= |(status & irq_en);
   assign irq = r_irq;
`else
   logic w_unused_irq_en;
   assign w_unused_irq_en = ^irq_en;
   assign irq             = 1'b0;
`endif

endmodule

// File: doc/de4_sopc_edge_event_unit.md
DE4_SOPC_EDGE_EVENT_UNIT -- requirements
Module: de4_sopc_edge_event_unit

Interface
REQ-001 Parameter WIDTH, default 8, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per channel ahead of edge detection (0..3; 0 = no synchronizer).
REQ-003 Parameter PULSE_LEN, default 1, output pulse length in clock cycles (1..255).
REQ-004 clock  input  1  single clock for all logic.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 data_in  input  WIDTH  level inputs, one per channel, asynchronous to clock when SYNC_STAGES>0.
REQ-007 edge_sel  input  2*WIDTH  per-channel mode, bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both.
REQ-008 data_out  output  WIDTH  registered per-channel event pulse.
REQ-009 status  output  WIDTH  sticky per-channel event flags.
REQ-010 status_clr  input  WIDTH  per-channel write-one-to-clear strobe for status.
REQ-011 irq_en  input  WIDTH  per-channel interrupt enable.
REQ-012 irq  output  1  registered interrupt request.

Function
REQ-013 Each channel SHALL pass data_in through SYNC_STAGES flops to form "sampled", then register sampled into "prev".
REQ-014 Event SHALL be: rising = sampled & ~prev; falling = ~sampled & prev; selected per edge_sel; mode 00 never produces events.
REQ-015 edge_sel SHALL be evaluated combinationally in the event cycle; changing it has no other side effect.
REQ-016 On an event in cycle N, data_out SHALL be high from cycle N+1 for exactly PULSE_LEN cycles.
REQ-017 Per-channel down-counter, width $clog2(PULSE_LEN+1); event loads PULSE_LEN; data_out high while counter nonzero.
REQ-018 Event during an active pulse SHALL reload the counter to PULSE_LEN (retrigger extends, never truncates).
REQ-019 Input change to data_out rise latency SHALL be SYNC_STAGES+1 clock edges.
REQ-020 status[i] SHALL set the cycle after an event on channel i and hold until cleared.
REQ-021 status_clr[i] SHALL clear status[i] the next cycle; simultaneous event and clear: set wins.
REQ-022 irq SHALL equal the registered OR of (status & irq_en), i.e. one cycle after status changes.
REQ-023 Channels SHALL be fully independent; no cross-channel ordering or priority.

Reset
REQ-024 reset_n low SHALL immediately clear sync flops, prev, counters, data_out, status and irq to 0.
REQ-025 Because prev resets to 0, an input held high through reset release SHALL produce one rising event SYNC_STAGES+1 edges after release.
REQ-026 Reset asserted mid-pulse SHALL terminate the pulse; no residual pulse after release.

Configuration
REQ-027 Macro DE4_SOPC_EDGE_EVENT_STICKY_EN defined: status, status_clr, irq_en and irq logic compiled in per REQ-020..022.
REQ-028 Macro undefined: status and irq SHALL be constant 0, status_clr and irq_en ignored; ports remain present; edge/pulse behaviour unchanged.

Structure
REQ-029 Package de4_sopc_edge_event_pkg SHALL hold the edge_sel encoding (edge_mode_t: NONE, RISE, FALL, BOTH) and parameter range limits.
REQ-030 Sub-module de4_sopc_edge_event_channel SHALL implement sync, prev, event decode, counter and sticky bit for one channel; top instantiates WIDTH copies in a generate loop plus the irq register.

Verification (WIDTH=4, SYNC_STAGES=2, PULSE_LEN=3, macro defined unless stated)
REQ-031 ch0 mode 01, data_in[0] 0->1 -> data_out[0] high exactly 3 cycles starting 3 edges after the change; 1->0 -> no pulse.
REQ-032 ch1 mode 10, toggle data_in[1] 0->1->0 -> one 3-cycle pulse on the falling change only; ch1 mode 00 -> no pulse, status[1] stays 0.
REQ-033 ch2 mode 11, toggles 2 cycles apart -> data_out[2] continuously high 5 cycles (retrigger reload).
REQ-034 ch3 event with irq_en[3]=1 -> status[3]=1 next cycle, irq=1 cycle after; status_clr[3] same cycle as new event -> status stays 1; clear alone -> status 0, irq 0 one cycle later.
REQ-035 reset_n pulsed low mid-pulse -> data_out, status, irq 0 immediately; data_in[0] held high across release -> one rising pulse 3 edges after release.
REQ-036 Macro undefined, rerun REQ-034 stimulus -> status=0 and irq=0 throughout; data_out matches REQ-031.
